// File: rtl/bcd_modulo_counter_pkg.sv
// Shared BCD types, digit limits and load-value validation for the modulo counter.
// Purpose: common definitions; no logic, no latency, no backpressure.
package bcd_cnt_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;

    // A load value is usable only if both nibbles are decimal and it fits the count range.
    function automatic logic bcd_valid(input logic [7:0] d, input int modulus);
        int val;
        val = int'(d[7:4]) * 10 + int'(d[3:0]);
        return (d[7:4] <= BCD_MAX) && (d[3:0] <= BCD_MAX) && (val <= modulus - 1);
    endfunction

endpackage

// File: rtl/bcd_modulo_counter_if.sv
// Control/data bundle of the BCD modulo counter; BCDCNT_DOWN_EN adds the Dn direction bit.
// Purpose: port grouping only; no latency; no backpressure (enable-driven counter).
interface bcd_modulo_counter_if;

    logic       Load;
    logic       En;
    logic [7:0] D;
    logic [7:0] Q;
    logic       CO;
`ifdef BCDCNT_DOWN_EN
    logic       Dn;
`endif

    modport master (
        output Load, En, D,
        input  Q, CO
`ifdef BCDCNT_DOWN_EN
        , output Dn
`endif
    );

    modport slave (
        input  Load, En, D,
        output Q, CO
`ifdef BCDCNT_DOWN_EN
        , input Dn
`endif
    );

endinterface

// File: rtl/bcd_modulo_counter_digit.sv
// One decade digit: load > inc > dec > hold, wrapping between 0 and WRAP.
// Latency one CP edge; no backpressure.
module bcd_digit
    import bcd_cnt_pkg::*;
#(
    parameter bcd_digit_t WRAP = BCD_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  bcd_digit_t d,
    output bcd_digit_t q,
    output logic       at_max,
    output logic       at_zero
);

    assign at_max  = (q == WRAP);
    assign at_zero = (q == BCD_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= at_max ? BCD_ZERO : q + 4'd1;
        end else if (dec) begin
            q <= at_zero ? WRAP : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_modulo_counter.sv
// Two-digit BCD modulo-MODULUS counter with load, enable and cascade carry; BCDCNT_DOWN_EN adds down-count.
// Latency one CP edge; CO is combinational; no backpressure (En gates counting).
module bcd_modulo_counter
    import bcd_cnt_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic                  CP,
    input  logic                  CLR,
    bcd_modulo_counter_if.slave   bus
);

    localparam logic [7:0] TERM = {4'((MODULUS - 1) / 10), 4'((MODULUS - 1) % 10)};

    bcd_digit_t units_q, tens_q;
    logic       units_at_max, units_at_zero;
    logic       tens_max_unused, tens_at_zero;
    logic [7:0] q;
    logic       at_term, at_floor, down;
    logic       ld;
    logic [7:0] ld_val;
    logic       units_inc, units_dec, tens_inc, tens_dec;

`ifdef BCDCNT_DOWN_EN
    assign down = bus.Dn;
`else
    assign down = 1'b0;
`endif

    assign q        = {tens_q, units_q};
    assign at_term  = (q == TERM);
    assign at_floor = units_at_zero && tens_at_zero;

    // The modulus wrap is done by loading both digits rather than by the digits' own wrap,
    // since the range ends at MODULUS-1, not at 99.
    always_comb begin
        ld        = 1'b0;
        ld_val    = 8'h00;
        units_inc = 1'b0;
        units_dec = 1'b0;
        tens_inc  = 1'b0;
        tens_dec  = 1'b0;
        if (bus.Load) begin
            ld     = 1'b1;
            ld_val = bcd_valid(bus.D, MODULUS) ? bus.D : 8'h00;
        end else if (bus.En && down) begin
            if (at_floor) begin
                ld     = 1'b1;
                ld_val = TERM;
            end else begin
                units_dec = 1'b1;
                tens_dec  = units_at_zero;
            end
        end else if (bus.En) begin
            if (at_term) begin
                ld = 1'b1;
            end else begin
                units_inc = 1'b1;
                tens_inc  = units_at_max;
            end
        end
    end

    bcd_digit #(.WRAP(BCD_MAX)) u_units (
        .clk     (CP),
        .rst     (CLR),
        .inc     (units_inc),
        .dec     (units_dec),
        .load    (ld),
        .d       (ld_val[3:0]),
        .q       (units_q),
        .at_max  (units_at_max),
        .at_zero (units_at_zero)
    );

    bcd_digit #(.WRAP(BCD_MAX)) u_tens (
        .clk     (CP),
        .rst     (CLR),
        .inc     (tens_inc),
        .dec     (tens_dec),
        .load    (ld),
        .d       (ld_val[7:4]),
        .q       (tens_q),
        .at_max  (tens_max_unused),
        .at_zero (tens_at_zero)
    );

    assign bus.Q  = q;
    assign bus.CO = !CLR && bus.En && (down ? at_floor : at_term);

endmodule

// File: tb/tb_bcd_modulo_counter.sv
// Scoreboarded bench for bcd_modulo_counter at MODULUS=60 and MODULUS=24 (BCDCNT_DOWN_EN adds down-count cases).
module tb_bcd_modulo_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst60, rst24;

    bcd_modulo_counter_if if60();
    bcd_modulo_counter_if if24();

    bcd_modulo_counter #(.MODULUS(60)) dut60 (.CP(clk), .CLR(rst60), .bus(if60));
    bcd_modulo_counter #(.MODULUS(24)) dut24 (.CP(clk), .CLR(rst24), .bus(if24));

    typedef struct {
        int         sel;
        logic [7:0] q;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errs    = 0;
    int   mdl[2];
    int   mods[2] = '{60, 24};

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] q_of(input int sel);
        return (sel == 0) ? if60.Q : if24.Q;
    endfunction

    function automatic logic [7:0] co_of(input int sel);
        return {7'd0, (sel == 0) ? if60.CO : if24.CO};
    endfunction

    task automatic set_in(input int sel, input logic ld, input logic en, input logic dn, input logic [7:0] d);
        if60.Load = 1'b0; if60.En = 1'b0; if60.D = 8'h00;
        if24.Load = 1'b0; if24.En = 1'b0; if24.D = 8'h00;
`ifdef BCDCNT_DOWN_EN
        if60.Dn = 1'b0; if24.Dn = 1'b0;
        if (sel == 0) if60.Dn = dn; else if24.Dn = dn;
`endif
        if (sel == 0) begin
            if60.Load = ld; if60.En = en; if60.D = d;
        end else begin
            if24.Load = ld; if24.En = en; if24.D = d;
        end
    endtask

    // One edge on the selected counter: check CO now, push the expected Q, pop it after the edge.
    task automatic step(input int sel, input logic ld, input logic en, input logic dn_req, input logic [7:0] d);
        int   m, v, hi, lo;
        logic dn, co_exp;
        exp_t e;
`ifdef BCDCNT_DOWN_EN
        dn = dn_req;
`else
        dn = 1'b0 & dn_req;
`endif
        @(negedge clk);
        set_in(sel, ld, en, dn, d);
        m = mods[sel];
        v = mdl[sel];
        #1;
        co_exp = en && (dn ? (v == 0) : (v == m - 1));
        chk(sel == 0 ? "co60" : "co24", co_of(sel), {7'd0, co_exp});
        hi = int'(d[7:4]);
        lo = int'(d[3:0]);
        if (ld)       v = (hi <= 9 && lo <= 9 && hi * 10 + lo < m) ? hi * 10 + lo : 0;
        else if (en)  v = dn ? ((v == 0) ? m - 1 : v - 1) : ((v + 1) % m);
        mdl[sel] = v;
        e.sel = sel;
        e.q   = bcd(v);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            chk(e.sel == 0 ? "q60" : "q24", q_of(e.sel), e.q);
        end
    endtask

    // Asynchronous clear between edges with En (and Dn) high: Q and CO must drop immediately.
    task automatic areset(input int sel);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b1, 1'b1, 8'h00);
        #2;
        if (sel == 0) rst60 = 1'b1; else rst24 = 1'b1;
        #1;
        chk("async_clr_q", q_of(sel), 8'h00);
        chk("async_clr_co", co_of(sel), 8'h00);
        set_in(sel, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        if (sel == 0) rst60 = 1'b0; else rst24 = 1'b0;
        mdl[sel] = 0;
    endtask

    initial begin
        rst60 = 1'b1;
        rst24 = 1'b1;
        mdl[0] = 0;
        mdl[1] = 0;
        set_in(0, 1'b0, 1'b1, 1'b0, 8'h00);
        #3;
        chk("rst_q60", if60.Q, 8'h00);
        chk("rst_q24", if24.Q, 8'h00);
        chk("rst_co60", {7'd0, if60.CO}, 8'h00);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst60 = 1'b0;
        rst24 = 1'b0;

        // Full modulo-60 cycle from 00 (covers 09->10 and 59->00), plus one more.
        repeat (61) step(0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Hold, load priority over En, terminal carry from a loaded 59.
        step(0, 1'b1, 1'b0, 1'b0, 8'h37);
        repeat (5) step(0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(0, 1'b1, 1'b1, 1'b0, 8'h45);
        step(0, 1'b1, 1'b0, 1'b0, 8'h59);
        step(0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Invalid loads collapse to 00.
        step(0, 1'b1, 1'b0, 1'b0, 8'h33);
        step(0, 1'b1, 1'b0, 1'b0, 8'h2A);
        step(0, 1'b1, 1'b0, 1'b0, 8'h33);
        step(0, 1'b1, 1'b0, 1'b0, 8'h60);
        step(0, 1'b1, 1'b0, 1'b0, 8'hA5);

        // Modulo-24: 20 -> 21 -> 22 -> 23 -> 00 -> 01.
        step(1, 1'b1, 1'b0, 1'b0, 8'h20);
        repeat (5) step(1, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1, 1'b1, 1'b0, 1'b0, 8'h23);
        step(1, 1'b1, 1'b0, 1'b0, 8'h24);

        // Asynchronous clear mid-count, then counting resumes from 00.
        repeat (7) step(0, 1'b0, 1'b1, 1'b0, 8'h00);
        areset(0);
        repeat (2) step(0, 1'b0, 1'b1, 1'b0, 8'h00);
        repeat (3) step(1, 1'b0, 1'b1, 1'b0, 8'h00);
        areset(1);
        step(1, 1'b0, 1'b1, 1'b0, 8'h00);

`ifdef BCDCNT_DOWN_EN
        // Down-count from 00 at MODULUS=24: 23, 22, ..., 20, 19, ... and wrap again.
        step(1, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (26) step(1, 1'b0, 1'b1, 1'b1, 8'h00);
        step(0, 1'b1, 1'b0, 1'b0, 8'h10);
        repeat (3) step(0, 1'b0, 1'b1, 1'b1, 8'h00);
`endif

        // Random mix on both counters.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            int         sel;
            sel = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                d = bcd(int'($urandom_range(0, 99)));
            else
                d = 8'($urandom_range(0, 255));
            step(sel, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, d);
        end

        if (sb.size() != 0) chk("sb_leftover", 8'(sb.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
